gamesys_wall_scheduler: RTL and testbench
=========================================

// Module: gamesys_wall_scheduler
// PURPOSE
//  Owns the state of the NUM_WALLS wall obstacles and drives the pos_wall_x/y/height arrays read by the wall pixel datapath.
//  On each game tick it walks the slots one per cycle: it scrolls each wall left, respawns walls that have left the screen
//  (with a new pseudo-random gap), and flags score events. The walls render path is purely combinational and
//  reads these registers continuously.
// PARAMETERS
//  NUM_WALLS     5       number of wall slots (index width = $clog2(NUM_WALLS))
//  POS_W         12      width of signed position fields; equals the system position width
//  SCREEN_W      640     initial x of slot 0
//  WALL_SPACING  160     x distance between consecutive slots
//  WALL_HALF_W   26      wall half-width; slot is off-screen when x < -WALL_HALF_W
//  GAP_HEIGHT    120     value driven on every pos_wall_height
//  GAP_Y_MIN     40      minimum gap top y
//  GAP_Y_SPAN    200     random gap offset range 0..GAP_Y_SPAN
//  INIT_GAP_Y    140     gap y loaded at reset/restart
//  BIRD_X        160     x at which a wall passing scores
//  LFSR_SEED     16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  base_clk         in   1            system clock; all logic on posedge
//  reset            in   1            asynchronous, active-low (0 = reset)
//  game_tick        in   1            1-cycle pulse, starts one frame update
//  run              in   1            1 = game active; ticks ignored while 0
//  restart          in   1            1-cycle pulse, reload initial layout
//  scroll_speed     in   4            pixels per tick (unsigned), sampled at tick accept
//  pos_wall_x       out  POS_W x N    signed wall centre x per slot
//  pos_wall_y       out  POS_W x N    signed gap top y per slot
//  pos_wall_height  out  POS_W x N    gap height per slot (always GAP_HEIGHT)
//  busy             out  1            1 while UPDATE/DONE active
//  frame_done       out  1            1-cycle pulse at end of a frame update
//  score_pulse      out  1            1-cycle pulse per wall crossing BIRD_X
// BEHAVIOUR
//  Reset (reset=0, async) and restart (sync, priority over everything): x[i]=SCREEN_W+i*WALL_SPACING, y[i]=INIT_GAP_Y,
//   height[i]=GAP_HEIGHT, state IDLE, busy=0, frame_done=0, score_pulse=0. Async reset also sets lfsr=LFSR_SEED and
//   spd=0; restart leaves lfsr as is.
//  FSM IDLE -> UPDATE -> DONE -> IDLE.
//   IDLE: game_tick & run -> UPDATE, idx=0, spd<=scroll_speed. Otherwise stay.
//   UPDATE: one slot per cycle, idx 0..NUM_WALLS-1. After idx==NUM_WALLS-1 -> DONE.
//   DONE: frame_done=1 for this cycle -> IDLE.
//  game_tick while busy: dropped, no queuing. run dropping to 0 mid-update: the update completes.
//  Per-slot update (computed in POS_W+2 signed, then truncated to POS_W):
//   xn = x[idx] - spd.
//   If xn < -WALL_HALF_W, respawn: x[idx]=xn+NUM_WALLS*WALL_SPACING; lfsr steps once (Galois, taps 16'hB400:
//    l=(l>>1)^(l[0]?16'hB400:0)); r=new_lfsr[7:0]; if r>GAP_Y_SPAN then r=r-(GAP_Y_SPAN+1); y[idx]=GAP_Y_MIN+r.
//   Otherwise: x[idx]=xn and y is unchanged.
//   score_pulse=1 in the cycle after the slot update when x_old>=BIRD_X and xn<BIRD_X. A crossing and a respawn in one slot
//    is impossible for sane params and needs no handling.
//  Outputs are registers that change slot-by-slot during UPDATE. Latency from tick accept to frame_done: NUM_WALLS+1 cycles.
//  spd=0 still runs the full FSM with no motion. Exact spacing is preserved by the respawn rule.
// TESTING
//  1 reset low -> x={640,800,960,1120,1280}, y all 140, height all 120, busy=0; release then no tick -> values hold.
//  2 speed=4, one tick -> busy 1 for 6 cycles, frame_done on cycle 6, x={636,796,956,1116,1276}.
//  3 preload slot0 x=-24 (via ticks), speed=4 -> xn=-28<-26 -> x[0]=772, lfsr 16'hE270, y[0]=40+112=152.
//  4 x[k]=162, speed=4 -> x=158, exactly one score_pulse; next tick from 158 gives no pulse.
//  5 game_tick on cycles 1 and 3 of an update -> second dropped, single 4-px move; restart mid-UPDATE -> initial layout, IDLE next cycle.
//  6 async reset asserted mid-UPDATE with no clock edge -> outputs at reset values immediately, lfsr=ACE1.

Source files
------------

// File: rtl/gamesys_wall_scheduler.sv
// Wall obstacle scheduler: walks the wall slots once per game tick, scrolling,
// respawning off-screen walls with an LFSR-chosen gap and flagging score crossings.
module gamesys_wall_scheduler #(
  parameter int unsigned NUM_WALLS    = 5,
  parameter int unsigned POS_W        = 12,
  parameter int          SCREEN_W     = 640,
  parameter int          WALL_SPACING = 160,
  parameter int          WALL_HALF_W  = 26,
  parameter int          GAP_HEIGHT   = 120,
  parameter int          GAP_Y_MIN    = 40,
  parameter int          GAP_Y_SPAN   = 200,
  parameter int          INIT_GAP_Y   = 140,
  parameter int          BIRD_X       = 160,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    base_clk,
  input  logic                    reset,
  input  logic                    game_tick,
  input  logic                    run,
  input  logic                    restart,
  input  logic [3:0]              scroll_speed,
  output logic signed [POS_W-1:0] pos_wall_x      [NUM_WALLS],
  output logic signed [POS_W-1:0] pos_wall_y      [NUM_WALLS],
  output logic signed [POS_W-1:0] pos_wall_height [NUM_WALLS],
  output logic                    busy,
  output logic                    frame_done,
  output logic                    score_pulse
);

  localparam int unsigned IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam int unsigned EXT_W = POS_W + 2;
  localparam logic signed [EXT_W-1:0] OFF_LIM = EXT_W'(-WALL_HALF_W);
  localparam logic signed [EXT_W-1:0] BIRD_E  = EXT_W'(BIRD_X);
  localparam logic signed [EXT_W-1:0] WRAP_E  = EXT_W'(int'(NUM_WALLS) * WALL_SPACING);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       spd;
  logic [15:0]      lfsr;

  logic signed [EXT_W-1:0] x_old_c, x_new_c, x_resp_c, spd_e_c;
  logic [15:0]             lfsr_next_c;
  logic [7:0]              gap_r_c;
  logic                    respawn_c, score_c;

  // Slot datapath for the slot currently addressed by idx
  always_comb begin
    x_old_c     = {{2{pos_wall_x[idx][POS_W-1]}}, pos_wall_x[idx]};
    spd_e_c     = {{(EXT_W-4){1'b0}}, spd};
    x_new_c     = x_old_c - spd_e_c;
    x_resp_c    = x_new_c + WRAP_E;
    respawn_c   = (x_new_c < OFF_LIM);
    lfsr_next_c = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    gap_r_c     = lfsr_next_c[7:0];
    if (gap_r_c > 8'(GAP_Y_SPAN)) begin
      gap_r_c = gap_r_c - 8'(GAP_Y_SPAN + 1);
    end
    score_c     = (x_old_c >= BIRD_E) && (x_new_c < BIRD_E);
  end

  always_ff @(posedge base_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      spd         <= '0;
      lfsr        <= LFSR_SEED;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      score_pulse <= 1'b0;
      for (int i = 0; i < int'(NUM_WALLS); i++) begin
        pos_wall_x[i]      <= POS_W'(SCREEN_W + i * WALL_SPACING);
        pos_wall_y[i]      <= POS_W'(INIT_GAP_Y);
        pos_wall_height[i] <= POS_W'(GAP_HEIGHT);
      end
    end else if (restart) begin
      // Restart reloads the layout but keeps the LFSR sequence running
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      score_pulse <= 1'b0;
      for (int i = 0; i < int'(NUM_WALLS); i++) begin
        pos_wall_x[i]      <= POS_W'(SCREEN_W + i * WALL_SPACING);
        pos_wall_y[i]      <= POS_W'(INIT_GAP_Y);
        pos_wall_height[i] <= POS_W'(GAP_HEIGHT);
      end
    end else begin
      frame_done  <= 1'b0;
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (game_tick && run) begin
            state <= UPDATE;
            idx   <= '0;
            spd   <= scroll_speed;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (respawn_c) begin
            pos_wall_x[idx] <= POS_W'(x_resp_c);
            pos_wall_y[idx] <= POS_W'(GAP_Y_MIN) + POS_W'(gap_r_c);
            lfsr            <= lfsr_next_c;
          end else begin
            pos_wall_x[idx] <= POS_W'(x_new_c);
          end
          score_pulse <= score_c;
          if (idx == IDX_W'(NUM_WALLS - 1)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamesys_wall_scheduler.sv
// Scoreboard bench for gamesys_wall_scheduler: each accepted tick pushes the expected
// frame; a monitor pops and compares on every frame_done.
module tb_gamesys_wall_scheduler;

  localparam int NW = 5;

  logic              clk;
  logic              rst_n;
  logic              game_tick;
  logic              run;
  logic              restart;
  logic [3:0]        scroll_speed;
  logic signed [11:0] pos_wall_x      [NW];
  logic signed [11:0] pos_wall_y      [NW];
  logic signed [11:0] pos_wall_height [NW];
  logic              busy;
  logic              frame_done;
  logic              score_pulse;

  gamesys_wall_scheduler dut (
    .base_clk        (clk),
    .reset           (rst_n),
    .game_tick       (game_tick),
    .run             (run),
    .restart         (restart),
    .scroll_speed    (scroll_speed),
    .pos_wall_x      (pos_wall_x),
    .pos_wall_y      (pos_wall_y),
    .pos_wall_height (pos_wall_height),
    .busy            (busy),
    .frame_done      (frame_done),
    .score_pulse     (score_pulse)
  );

  typedef struct {
    int x[NW];
    int y[NW];
    int sc;
  } frame_t;

  frame_t      q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          sc_acc = 0;
  int          mx[NW];
  int          my[NW];
  logic [15:0] mlfsr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_layout();
    for (int i = 0; i < NW; i++) begin
      mx[i] = 640 + 160 * i;
      my[i] = 140;
    end
  endfunction

  // Reference frame update, pushed to the scoreboard
  task automatic model_tick(input int sp);
    frame_t e;
    int xo, xn, r;
    e.sc = 0;
    for (int i = 0; i < NW; i++) begin
      xo = mx[i];
      xn = xo - sp;
      if (xn < -26) begin
        mx[i] = xn + 800;
        mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
        r = int'(mlfsr[7:0]);
        if (r > 200) r = r - 201;
        my[i] = 40 + r;
      end else begin
        mx[i] = xn;
      end
      if (xo >= 160 && xn < 160) e.sc++;
    end
    e.x = mx;
    e.y = my;
    q.push_back(e);
  endtask

  function automatic void flush();
    q.delete();
    sc_acc = 0;
  endfunction

  // Monitor: score pulses accumulate until frame_done, then the frame is compared
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (score_pulse) sc_acc++;
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < NW; i++) begin
            chk($sformatf("frame_x%0d", i), int'(pos_wall_x[i]), e.x[i]);
            chk($sformatf("frame_y%0d", i), int'(pos_wall_y[i]), e.y[i]);
            chk($sformatf("frame_h%0d", i), int'(pos_wall_height[i]), 120);
          end
          chk("frame_scores", sc_acc, e.sc);
        end
        sc_acc = 0;
      end
    end
  end

  // Issue one tick and follow the update to its end; extra_at>0 pulses another tick mid-update
  task automatic do_tick(input int sp, input int extra_at,
                         output int busy_cyc, output int fd_cyc, output int sc);
    model_tick(sp);
    game_tick    = 1'b1;
    run          = 1'b1;
    scroll_speed = 4'(sp);
    @(posedge clk);
    #1 game_tick = 1'b0;
    busy_cyc = 0;
    fd_cyc   = 0;
    sc       = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      game_tick = (c == extra_at) ? 1'b1 : 1'b0;
      if (busy) busy_cyc++;
      if (frame_done) fd_cyc = c;
      if (score_pulse) sc++;
      if (!busy) break;
    end
    game_tick = 1'b0;
    chk("update_ends", int'(busy), 0);
  endtask

  task automatic check_layout(input string tag);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(pos_wall_x[i]), 640 + 160 * i);
      chk($sformatf("%s_y%0d", tag, i), int'(pos_wall_y[i]), 140);
      chk($sformatf("%s_h%0d", tag, i), int'(pos_wall_height[i]), 120);
    end
    chk($sformatf("%s_busy", tag), int'(busy), 0);
    chk($sformatf("%s_fd", tag), int'(frame_done), 0);
    chk($sformatf("%s_score", tag), int'(score_pulse), 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    flush();
    model_layout();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, fc, sc;
    rst_n = 1'b0; game_tick = 1'b0; run = 1'b0; restart = 1'b0; scroll_speed = 4'd0;
    mlfsr = 16'hACE1;
    model_layout();

    // Reset state, then hold with no tick
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_layout("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_layout("hold");

    // Single tick at speed 4: timing and positions
    do_tick(4, 0, bc, fc, sc);
    chk("t2_busy_cycles", bc, 6);
    chk("t2_fd_cycle", fc, 6);
    chk("t2_scores", sc, 0);
    for (int i = 0; i < NW; i++) chk($sformatf("t2_x%0d", i), int'(pos_wall_x[i]), 636 + 160 * i);

    // Walk slot 0 to x=-24, then respawn
    for (int k = 0; k < 44; k++) do_tick(15, 0, bc, fc, sc);
    chk("t3_pre_x0", int'(pos_wall_x[0]), -24);
    do_tick(4, 0, bc, fc, sc);
    chk("t3_x0", int'(pos_wall_x[0]), 772);
    chk("t3_y0", int'(pos_wall_y[0]), 152);
    chk("t3_x1", int'(pos_wall_x[1]), 132);

    // Score crossing from 162 to 158, then none from 158
    do_restart();
    @(negedge clk);
    check_layout("restart");
    for (int k = 0; k < 31; k++) do_tick(15, 0, bc, fc, sc);
    do_tick(13, 0, bc, fc, sc);
    chk("t4_pre_x0", int'(pos_wall_x[0]), 162);
    do_tick(4, 0, bc, fc, sc);
    chk("t4_x0", int'(pos_wall_x[0]), 158);
    chk("t4_score_once", sc, 1);
    do_tick(4, 0, bc, fc, sc);
    chk("t4_x0_next", int'(pos_wall_x[0]), 154);
    chk("t4_no_score", sc, 0);

    // Tick ignored while run is low
    run = 1'b0; game_tick = 1'b1;
    @(posedge clk);
    #1 game_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("norun_busy", int'(busy), 0);
    chk("norun_x0", int'(pos_wall_x[0]), 154);

    // Tick during update is dropped
    do_restart();
    do_tick(4, 3, bc, fc, sc);
    chk("t5_busy_cycles", bc, 6);
    repeat (3) @(negedge clk);
    chk("t5_no_requeue", int'(busy), 0);
    chk("t5_x0", int'(pos_wall_x[0]), 636);

    // Restart mid-update
    do_restart();
    game_tick = 1'b1; run = 1'b1; scroll_speed = 4'd4;
    @(posedge clk);
    #1 game_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    flush();
    @(negedge clk);
    check_layout("t5_restart");
    repeat (8) @(negedge clk);
    chk("t5_idle_after", int'(busy), 0);

    // Async reset mid-update with no clock edge
    game_tick = 1'b1; scroll_speed = 4'd4;
    @(posedge clk);
    #1 game_tick = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_layout("t6_async");
    chk("t6_lfsr", int'(dut.lfsr), 32'h0000ACE1);
    flush();
    mlfsr = 16'hACE1;
    model_layout();
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(4, 0, bc, fc, sc);
    chk("t6_after_x0", int'(pos_wall_x[0]), 636);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
